// File: rtl/whirlpool_round_seq.sv
// whirlpool_round_seq: iterative Whirlpool compression sequencer.
// Drives a shared external round unit; Miyaguchi-Preneel output.
module whirlpool_round_seq #(
   parameter int ROUNDS = 10
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [511:0] block_in,
   input  logic [511:0] chain_in,
   output logic [3:0]   rc_idx,
   input  logic [511:0] rc_in,
   output logic [511:0] rnd_in,
   output logic [511:0] rnd_key,
   input  logic [511:0] rnd_out,
   output logic         busy,
   output logic         done,
   output logic [511:0] hash_out
);

   localparam logic [3:0] LAST_R = 4'(ROUNDS);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_KEY,
      ST_STATE,
      ST_FIN
   } state_t;

   state_t       state_q, state_d;
   logic [3:0]   r_q, r_d;
   logic [511:0] k_q, k_d;
   logic [511:0] s_q, s_d;
   logic [511:0] m_q, m_d;
   logic [511:0] hs_q, hs_d;
   logic [511:0] hash_q, hash_d;
   logic         done_q, done_d;

   // sequencing: key round then state round, ROUNDS times, then feed-forward
   always_comb begin
      state_d = state_q;
      r_d     = r_q;
      k_d     = k_q;
      s_d     = s_q;
      m_d     = m_q;
      hs_d    = hs_q;
      hash_d  = hash_q;
      done_d  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               k_d     = chain_in;
               s_d     = block_in ^ chain_in;
               m_d     = block_in;
               hs_d    = chain_in;
               r_d     = 4'd1;
               state_d = ST_KEY;
            end
         end
         ST_KEY: begin
            k_d     = rnd_out;
            state_d = ST_STATE;
         end
         ST_STATE: begin
            s_d = rnd_out;
            if (r_q == LAST_R) begin
               state_d = ST_FIN;
            end else begin
               r_d     = r_q + 4'd1;
               state_d = ST_KEY;
            end
         end
         ST_FIN: begin
            hash_d  = s_q ^ m_q ^ hs_q;
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // round-unit operands: key schedule uses RC, state round uses K
   always_comb begin
      rnd_in  = s_q;
      rnd_key = '0;
      rc_idx  = 4'd0;
      unique case (state_q)
         ST_KEY: begin
            rnd_in  = k_q;
            rnd_key = rc_in;
            rc_idx  = r_q;
         end
         ST_STATE: begin
            rnd_in  = s_q;
            rnd_key = k_q;
            rc_idx  = r_q;
         end
         default: begin
            rnd_in  = s_q;
            rnd_key = '0;
            rc_idx  = 4'd0;
         end
      endcase
   end

   // state registers with asynchronous clear
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         r_q     <= 4'd0;
         k_q     <= '0;
         s_q     <= '0;
         m_q     <= '0;
         hs_q    <= '0;
         hash_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         k_q     <= k_d;
         s_q     <= s_d;
         m_q     <= m_d;
         hs_q    <= hs_d;
         hash_q  <= hash_d;
         done_q  <= done_d;
      end
   end

   assign busy     = (state_q != ST_IDLE);
   assign done     = done_q;
   assign hash_out = hash_q;

endmodule
